wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file of the MIPS-like pipeline, placed directly after the MEM/WB pipeline register. It selects the write-back value from the ALU result, the load data or the jal link address, and writes it into a 2^ASIZE-entry register file. It serves two combinational read ports to the ID stage and drives a registered one-cycle commit record for trace and debug.

## Interface
Parameters:
- DSIZE, 32, data and register width.
- ASIZE, 5, register address width; the file holds 2^ASIZE entries.
- ISIZE, 32, nPC width; ISIZE ≤ DSIZE.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- rst  in  1  asynchronous, active-high reset.
- waddr_in  in  ASIZE  destination register from MEM/WB.
- aluout_in  in  DSIZE  ALU result from MEM/WB.
- mem_rdata_in  in  DSIZE  data memory read data for the instruction currently in WB.
- wen_in  in  1  register write enable.
- memtoreg_in  in  1  1 selects mem_rdata_in, 0 selects aluout_in.
- jal_in  in  1  link write; overrides memtoreg_in and waddr_in.
- nPC_in  in  ISIZE  link address (PC+1 of the jal).
- raddr1, raddr2  in  ASIZE  ID-stage read addresses.
- rdata1, rdata2  out  DSIZE  read data, combinational.
- commit_valid  out  1  registered; a write retired last cycle.
- commit_addr  out  ASIZE  registered address of that write.
- commit_data  out  DSIZE  registered data of that write.

## Operation
- wb_data = jal_in ? zero-extended nPC_in : (memtoreg_in ? mem_rdata_in : aluout_in).
- wb_addr = jal_in ? all-ones (register 31 when ASIZE=5) : waddr_in.
- wb_we = (wen_in | jal_in) & (wb_addr != 0).
- Register 0 is not stored. It reads 0 and ignores writes.
- On each posedge with wb_we = 1: regs[wb_addr] <= wb_data.
- Read ports: rdata = (raddr == 0) ? 0 : regs[raddr], subject to the bypass defined under Configuration.
- Commit record, updated every posedge: commit_valid <= wb_we; commit_addr and commit_data <= wb_addr and wb_data when wb_we = 1, otherwise hold their previous values.
- Inputs are sampled every cycle; there is no stall or valid handshake. Bubbles arrive with wen_in = jal_in = 0.

## Timing
- Reset: on rst assertion, all registers, commit_valid, commit_addr and commit_data go to 0 immediately, without waiting for clk. rdata1 and rdata2 therefore read 0 while rst is high.
- Reset mid-operation: a write coinciding with an rst-high edge is lost. The first write after release takes effect on the first posedge with rst low.
- Write latency: 1 cycle. Without bypass, the new value is visible on rdata at the start of the cycle after the write edge.
- The commit outputs lag the write-back inputs by exactly 1 cycle.
- Both read ports may address the same register, or the register being written, in the same cycle. Each port resolves independently.
- When jal_in and memtoreg_in are both high, the jal path wins.

## Configuration
- WB_BYPASS_EN defined: a read port whose raddr equals wb_addr while wb_we = 1 returns wb_data in the same cycle (write-through). This removes the WB→ID hazard. Address 0 is never bypassed.
- WB_BYPASS_EN undefined: reads always return stored contents. The hazard unit must cover the WB→ID distance.

## Structure
- The shared package/define file holds DSIZE, ASIZE and ISIZE, plus a LINK_REG constant equal to the all-ones address.
- The write-back select (wb_data, wb_addr, wb_we) is a natural sub-module, wb_mux. It is purely combinational.
- The storage array, read ports, bypass and commit register stay in wb_regfile.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst asynchronously between edges -> rdata for r5 reads 0 immediately; commit_valid = 0.
- ALU write: aluout_in = 0x12345678, waddr_in = 3, wen_in = 1 -> next cycle rdata1 (raddr1 = 3) = 0x12345678; commit_valid = 1, commit_addr = 3, commit_data = 0x12345678.
- Load select: memtoreg_in = 1, mem_rdata_in = 0xA5A5A5A5, aluout_in = 0x1, waddr_in = 7 -> r7 = 0xA5A5A5A5.
- jal: jal_in = 1, nPC_in = 0x40, waddr_in = 9, wen_in = 0 -> r31 = 0x40; r9 is unchanged.
- r0 protection: wen_in = 1, waddr_in = 0, aluout_in = 0xFFFFFFFF -> rdata for r0 = 0; commit_valid = 0.
- Bypass: write 0x55 to r4 while raddr2 = 4 in the same cycle.
  - With WB_BYPASS_EN defined -> rdata2 = 0x55 in that cycle.
  - With WB_BYPASS_EN undefined -> rdata2 shows the old value in that cycle and 0x55 the next cycle.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared sizing for the write-back stage and general-purpose register file.
package wb_regfile_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;
    localparam int ISIZE = 32;

    // jal always links into the highest-numbered register
    localparam logic [ASIZE-1:0] LINK_REG = {ASIZE{1'b1}};

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back select: picks the value, destination and write strobe for the
// instruction sitting in WB. Purely combinational.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE = wb_regfile_pkg::DSIZE,
    parameter int ASIZE = wb_regfile_pkg::ASIZE,
    parameter int ISIZE = wb_regfile_pkg::ISIZE
) (
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_aluout,
    input  logic [DSIZE-1:0] i_mem_rdata,
    input  logic             i_wen,
    input  logic             i_memtoreg,
    input  logic             i_jal,
    input  logic [ISIZE-1:0] i_npc,
    output logic [DSIZE-1:0] o_wb_data,
    output logic [ASIZE-1:0] o_wb_addr,
    output logic             o_wb_we
);

    // Link register address for whatever ASIZE this instance is built with
    localparam logic [ASIZE-1:0] L_LINK = {ASIZE{1'b1}};

    // jal wins over both memtoreg and waddr; writes to r0 are dropped here
    always_comb begin
        o_wb_data = i_memtoreg ? i_mem_rdata : i_aluout;
        o_wb_addr = i_waddr;
        if (i_jal) begin
            o_wb_data = DSIZE'(i_npc);
            o_wb_addr = L_LINK;
        end
        o_wb_we = (i_wen | i_jal) & (o_wb_addr != '0);
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and register file. Two combinational read ports for ID,
// one write port from the WB select, and a registered commit record.
// Optional feature: define WB_BYPASS_EN to forward the write-back value to a
// read port addressing the register being written in the same cycle.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE = wb_regfile_pkg::DSIZE,
    parameter int ASIZE = wb_regfile_pkg::ASIZE,
    parameter int ISIZE = wb_regfile_pkg::ISIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] mem_rdata_in,
    input  logic             wen_in,
    input  logic             memtoreg_in,
    input  logic             jal_in,
    input  logic [ISIZE-1:0] nPC_in,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic             commit_valid,
    output logic [ASIZE-1:0] commit_addr,
    output logic [DSIZE-1:0] commit_data
);

    localparam int NREG = 1 << ASIZE;

    logic [DSIZE-1:0] w_wb_data;
    logic [ASIZE-1:0] w_wb_addr;
    logic             w_wb_we;

    // r0 is hardwired to zero, so storage starts at index 1
    logic [DSIZE-1:0] r_regs [1:NREG-1];

    logic             r_commit_valid;
    logic [ASIZE-1:0] r_commit_addr;
    logic [DSIZE-1:0] r_commit_data;

    wb_mux #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .ISIZE (ISIZE)
    ) u_wb_mux (
        .i_waddr     (waddr_in),
        .i_aluout    (aluout_in),
        .i_mem_rdata (mem_rdata_in),
        .i_wen       (wen_in),
        .i_memtoreg  (memtoreg_in),
        .i_jal       (jal_in),
        .i_npc       (nPC_in),
        .o_wb_data   (w_wb_data),
        .o_wb_addr   (w_wb_addr),
        .o_wb_we     (w_wb_we)
    );

    // Storage write; w_wb_we is already low for address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[w_wb_addr] <= w_wb_data;
        end
    end

    // Read ports resolve independently; r0 reads zero and is never forwarded
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = r_regs[raddr1];
`ifdef WB_BYPASS_EN
            if (w_wb_we && (raddr1 == w_wb_addr)) begin
                rdata1 = w_wb_data;
            end
`endif
        end
        if (raddr2 != '0) begin
            rdata2 = r_regs[raddr2];
`ifdef WB_BYPASS_EN
            if (w_wb_we && (raddr2 == w_wb_addr)) begin
                rdata2 = w_wb_data;
            end
`endif
        end
    end

    // Commit record: valid pulses per retired write, addr/data hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_valid <= 1'b0;
            r_commit_addr  <= '0;
            r_commit_data  <= '0;
        end else begin
            r_commit_valid <= w_wb_we;
            if (w_wb_we) begin
                r_commit_addr <= w_wb_addr;
                r_commit_data <= w_wb_data;
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_addr  = r_commit_addr;
    assign commit_data  = r_commit_data;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  waddr_in;
    logic [31:0] aluout_in;
    logic [31:0] mem_rdata_in;
    logic        wen_in;
    logic        memtoreg_in;
    logic        jal_in;
    logic [31:0] nPC_in;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        commit_valid;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .waddr_in     (waddr_in),
        .aluout_in    (aluout_in),
        .mem_rdata_in (mem_rdata_in),
        .wen_in       (wen_in),
        .memtoreg_in  (memtoreg_in),
        .jal_in       (jal_in),
        .nPC_in       (nPC_in),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain array of architectural registers plus last commit
    logic [31:0] m_regs [32];
    logic        m_cv;
    logic [4:0]  m_ca;
    logic [31:0] m_cd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_dest();
        return jal_in ? 5'd31 : waddr_in;
    endfunction

    function automatic logic [31:0] m_data();
        if (jal_in) return nPC_in;
        return memtoreg_in ? mem_rdata_in : aluout_in;
    endfunction

    function automatic logic m_we();
        return (wen_in || jal_in) && (m_dest() != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && m_we() && a == m_dest()) return m_data();
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cv = 1'b0;
        m_ca = 5'd0;
        m_cd = 32'h0;
    endtask

    // one clock edge: model absorbs the inputs present at the edge
    task automatic tick();
        logic        we;
        logic [4:0]  d;
        logic [31:0] v;
        we = m_we();
        d  = m_dest();
        v  = m_data();
        @(posedge clk);
        if (!rst) begin
            m_cv = we;
            if (we) begin
                m_regs[d] = v;
                m_ca = d;
                m_cd = v;
            end
        end
        #1;
    endtask

    task automatic bubble();
        wen_in      = 1'b0;
        jal_in      = 1'b0;
        memtoreg_in = 1'b0;
    endtask

    task automatic chk_commit(input string tag);
        chk({tag, ".cv"}, {31'h0, commit_valid}, {31'h0, m_cv});
        chk({tag, ".ca"}, {27'h0, commit_addr}, {27'h0, m_ca});
        chk({tag, ".cd"}, commit_data, m_cd);
    endtask

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        wen;
        logic        m2r;
        logic        jal;
        logic [31:0] npc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_cv;
        logic [4:0]  e_ca;
        logic [31:0] e_cd;
    } vec_t;

    vec_t tv [7];

    initial begin
        // write address, alu, mem, wen, m2r, jal, npc, ra1, ra2 | rd1, rd2, cv, ca, cd (next cycle)
        tv[0] = '{5'd3, 32'h12345678, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,  5'd3,  5'd0, 32'h12345678, 32'h0,        1'b1, 5'd3,  32'h12345678};
        tv[1] = '{5'd7, 32'h00000001, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0,  5'd7,  5'd3, 32'hA5A5A5A5, 32'h12345678, 1'b1, 5'd7,  32'hA5A5A5A5};
        tv[2] = '{5'd9, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 5'd31, 5'd9, 32'h00000040, 32'h0,        1'b1, 5'd31, 32'h00000040};
        tv[3] = '{5'd5, 32'h0,        32'hBEEF,     1'b1, 1'b1, 1'b1, 32'h44, 5'd31, 5'd5, 32'h00000044, 32'h0,        1'b1, 5'd31, 32'h00000044};
        tv[4] = '{5'd0, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,  5'd0,  5'd0, 32'h0,        32'h0,        1'b0, 5'd31, 32'h00000044};
        tv[5] = '{5'd3, 32'h00000999, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  5'd3,  5'd7, 32'h12345678, 32'hA5A5A5A5, 1'b0, 5'd31, 32'h00000044};
        tv[6] = '{5'd3, 32'h00000BAD, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,  5'd3,  5'd31,32'h00000BAD, 32'h00000044, 1'b1, 5'd3,  32'h00000BAD};

        rst = 1'b1;
        waddr_in = 5'd0; aluout_in = 32'h0; mem_rdata_in = 32'h0; nPC_in = 32'h0;
        raddr1 = 5'd1; raddr2 = 5'd31;
        bubble();
        m_clear();
        #2;
        chk("reset.rd1", rdata1, 32'h0);
        chk("reset.rd2", rdata2, 32'h0);
        chk_commit("reset");
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // directed vectors
        for (int i = 0; i < 7; i++) begin
            waddr_in = tv[i].waddr; aluout_in = tv[i].alu; mem_rdata_in = tv[i].mem;
            wen_in = tv[i].wen; memtoreg_in = tv[i].m2r; jal_in = tv[i].jal;
            nPC_in = tv[i].npc; raddr1 = tv[i].ra1; raddr2 = tv[i].ra2;
            tick();
            bubble();
            #1;
            chk($sformatf("vec%0d.rd1", i), rdata1, tv[i].e_rd1);
            chk($sformatf("vec%0d.rd2", i), rdata2, tv[i].e_rd2);
            chk($sformatf("vec%0d.cv", i), {31'h0, commit_valid}, {31'h0, tv[i].e_cv});
            chk($sformatf("vec%0d.ca", i), {27'h0, commit_addr}, {27'h0, tv[i].e_ca});
            chk($sformatf("vec%0d.cd", i), commit_data, tv[i].e_cd);
        end

        // same-cycle read of the register being written
        waddr_in = 5'd4; aluout_in = 32'h11; wen_in = 1'b1;
        tick();
        waddr_in = 5'd4; aluout_in = 32'h55; wen_in = 1'b1;
        raddr1 = 5'd0; raddr2 = 5'd4;
        #2;
        chk("bypass.rd2_same", rdata2, BYPASS ? 32'h55 : 32'h11);
        chk("bypass.rd1_r0", rdata1, 32'h0);
        tick();
        bubble();
        #1;
        chk("bypass.rd2_next", rdata2, 32'h55);
        chk_commit("bypass");
        jal_in = 1'b1; nPC_in = 32'h1234; raddr1 = 5'd31; raddr2 = 5'd31;
        #2;
        chk("bypass.jal_rd1", rdata1, BYPASS ? 32'h1234 : 32'h0BAD_0000 ^ 32'h0BAD_0000 ^ m_regs[31]);
        chk("bypass.jal_rd2", rdata2, BYPASS ? 32'h1234 : m_regs[31]);
        tick();
        bubble();
        chk("jal.r31", rdata1, 32'h1234);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            waddr_in     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            aluout_in    = $urandom;
            mem_rdata_in = $urandom;
            nPC_in       = $urandom;
            wen_in       = ($urandom_range(0, 3) != 0);
            memtoreg_in  = $urandom_range(0, 1) == 1;
            jal_in       = ($urandom_range(0, 7) == 0);
            raddr1       = ($urandom_range(0, 2) == 0) ? m_dest() : 5'($urandom_range(0, 31));
            raddr2       = ($urandom_range(0, 2) == 0) ? m_dest() : 5'($urandom_range(0, 31));
            #2;
            chk($sformatf("rand%0d.rd1", c), rdata1, m_read(raddr1));
            chk($sformatf("rand%0d.rd2", c), rdata2, m_read(raddr2));
            tick();
            chk_commit($sformatf("rand%0d", c));
        end

        // asynchronous reset between edges, then write lost under reset
        bubble();
        waddr_in = 5'd5; aluout_in = 32'hDEADBEEF; wen_in = 1'b1;
        raddr1 = 5'd5; raddr2 = 5'd6;
        tick();
        bubble();
        #1;
        chk("prerst.r5", rdata1, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        m_clear();
        chk("rst.r5", rdata1, 32'h0);
        chk_commit("rst");
        waddr_in = 5'd6; aluout_in = 32'h66; wen_in = 1'b1;
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("rst.lost_r6", rdata2, 32'h0);
        chk_commit("rst.edge");
        tick();
        bubble();
        #1;
        chk("rst.first_r6", rdata2, 32'h66);
        chk_commit("rst.first");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
